// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the debounced button channels.
package button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_HELD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_REL_DB   = 3'd4
    } btn_state_t;

    // Bits needed to count up to the largest of the three timing parameters.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/button_chan.sv
// One button channel: synchroniser, debounce/repeat FSM and its single counter.
module button_chan
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Bis,
    output logic Bo,
    output logic Br,
    output logic Bl
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    // The sample that leaves IDLE/HELD already counts as the first stable one.
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 2);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    btn_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   bo_d, br_d, bl_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], Bis};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            Bo      <= 1'b0;
            Br      <= 1'b0;
            Bl      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            Bo      <= bo_d;
            Br      <= br_d;
            Bl      <= bl_d;
        end
    end

    // Next state; every path not listed falls back to IDLE with a cleared counter.
    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bo_d    = 1'b0;
        br_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s) state_d = ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (s) begin
                    if (cnt_q == DB_LAST) begin
                        state_d = ST_HELD;
                        bo_d    = 1'b1;
                    end else begin
                        state_d = ST_PRESS_DB;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_REL_DB;
                end else if (REPEAT_EN != 0 && cnt_q == RD_LAST) begin
                    state_d = ST_REPEAT;
                    bo_d    = 1'b1;
                end else begin
                    state_d = ST_HELD;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!s) begin
                    state_d = ST_REL_DB;
                end else if (cnt_q == RP_LAST) begin
                    state_d = ST_REPEAT;
                    bo_d    = 1'b1;
                end else begin
                    state_d = ST_REPEAT;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_REL_DB: begin
                if (s) begin
                    state_d = ST_HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    br_d    = 1'b1;
                end else begin
                    state_d = ST_REL_DB;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        bl_d = (state_d == ST_HELD) || (state_d == ST_REPEAT) || (state_d == ST_REL_DB);
    end

endmodule

// File: rtl/button_pulse_bank.sv
// Bank of independent debounced buttons with press, release and level outputs.
module button_pulse_bank #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [N_CH-1:0] Bis,
    output logic [N_CH-1:0] Bo,
    output logic [N_CH-1:0] Br,
    output logic [N_CH-1:0] Bl
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        button_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .Clk  (Clk),
            .Rst_n(Rst_n),
            .Bis  (Bis[i]),
            .Bo   (Bo[i]),
            .Br   (Br[i]),
            .Bl   (Bl[i])
        );
    end

endmodule

// File: tb/tb_button_pulse_bank.sv
// Bench for button_pulse_bank: fixed vectors, timed corner sequences and a random run against a run-length model.
module tb_button_pulse_bank;

    localparam int N    = 2;
    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;

    logic         Clk;
    logic         Rst_n;
    logic [N-1:0] Bis;
    logic [N-1:0] Bo, Br, Bl;

    button_pulse_bank #(
        .N_CH(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Bis(Bis), .Bo(Bo), .Br(Br), .Bl(Bl)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: synchroniser as a plain delay line, then run-length acceptance.
    logic [SYNC-1:0] mh [N];
    bit              m_lvl [N];
    int              m_run [N];
    int              m_age [N];
    logic [N-1:0]    m_bo, m_br, m_bl;

    int q_bo [N][$];
    int q_br [N][$];
    int eq[$];

    typedef struct {
        logic [N-1:0] bis;
        logic [N-1:0] bo;
        logic [N-1:0] br;
        logic [N-1:0] bl;
    } vec_t;
    vec_t tbl [18];

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            mh[c] = '0; m_lvl[c] = 0; m_run[c] = 0; m_age[c] = 0;
        end
        m_bo = '0; m_br = '0; m_bl = '0;
    endtask

    task automatic model_edge();
        logic s;
        if (!Rst_n) begin
            model_clear();
            return;
        end
        for (int c = 0; c < N; c++) begin
            s = mh[c][SYNC-1];
            mh[c] = {mh[c][SYNC-2:0], Bis[c]};
            m_bo[c] = 1'b0;
            m_br[c] = 1'b0;
            if (!m_lvl[c]) begin
                m_run[c] = s ? m_run[c] + 1 : 0;
                if (m_run[c] == DB) begin
                    m_lvl[c] = 1; m_bo[c] = 1'b1; m_run[c] = 0; m_age[c] = 0;
                end
            end else if (!s) begin
                m_run[c]++;
                m_age[c] = 0;
                if (m_run[c] == DB) begin
                    m_lvl[c] = 0; m_br[c] = 1'b1; m_run[c] = 0;
                end
            end else if (m_run[c] > 0) begin
                m_run[c] = 0;
                m_age[c] = 0;
            end else begin
                m_age[c]++;
                if (m_age[c] >= RD && (m_age[c] - RD) % RP == 0) m_bo[c] = 1'b1;
            end
            m_bl[c] = m_lvl[c];
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        cyc++;
        checks++;
        if ({Bo, Br, Bl} !== {m_bo, m_br, m_bl}) begin
            errors++;
            $display("FAIL model cyc=%0d got bo=%b br=%b bl=%b want bo=%b br=%b bl=%b",
                     cyc, Bo, Br, Bl, m_bo, m_br, m_bl);
        end
    endtask

    task automatic chk(input string name, input logic [3*N-1:0] got, input logic [3*N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {bo,br,bl}=%b want %b", name, got, exp);
        end
    endtask

    task automatic capture(input int n);
        for (int c = 0; c < N; c++) begin
            q_bo[c].delete();
            q_br[c].delete();
        end
        for (int k = 1; k <= n; k++) begin
            step();
            for (int c = 0; c < N; c++) begin
                if (Bo[c]) q_bo[c].push_back(k);
                if (Br[c]) q_br[c].push_back(k);
            end
        end
    endtask

    task automatic check_q(input string name, input int got[$], input int exp[$]);
        bit ok;
        ok = (got.size() == exp.size());
        if (ok) for (int i = 0; i < got.size(); i++) if (got[i] != exp[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s pulse steps got %p want %p", name, got, exp);
        end
    endtask

    initial begin
        int rem [N];
        Rst_n = 1'b0;
        Bis   = '0;
        model_clear();

        // Reset state
        step();
        chk("reset_state", {Bo, Br, Bl}, '0);
        step();
        Rst_n = 1'b1;
        repeat (3) step();

        // Clean press and release on channel 0, hand-derived expectations
        for (int r = 0; r < 18; r++) begin
            tbl[r].bis = (r < 10) ? 2'b01 : 2'b00;
            tbl[r].bo  = (r == 5) ? 2'b01 : 2'b00;
            tbl[r].br  = (r == 15) ? 2'b01 : 2'b00;
            tbl[r].bl  = (r >= 5 && r < 15) ? 2'b01 : 2'b00;
        end
        for (int r = 0; r < 18; r++) begin
            Bis = tbl[r].bis;
            step();
            chk($sformatf("table[%0d]", r), {Bo, Br, Bl}, {tbl[r].bo, tbl[r].br, tbl[r].bl});
        end
        Bis = '0;
        repeat (4) step();

        // Bounce 1,0,1 then hold for 30 cycles past the press, then release
        Bis = 2'b01; capture(2);
        check_q("bounce_hi1_bo", q_bo[0], eq);
        Bis = 2'b00; capture(2);
        check_q("bounce_lo_bo", q_bo[0], eq);
        Bis = 2'b01; capture(36);
        eq = {6, 16, 21, 26, 31, 36};
        check_q("hold_repeat_bo", q_bo[0], eq);
        eq.delete();
        check_q("hold_br", q_br[0], eq);
        Bis = 2'b00; capture(10);
        check_q("release_bo", q_bo[0], eq);
        eq = {6};
        check_q("release_br", q_br[0], eq);
        eq.delete();

        // Both channels together, then release them one at a time
        Bis = 2'b11; capture(6);
        eq = {6};
        check_q("simul_bo0", q_bo[0], eq);
        check_q("simul_bo1", q_bo[1], eq);
        Bis = 2'b10; capture(7);
        check_q("ch0_release_br0", q_br[0], eq);
        eq.delete();
        check_q("ch0_release_bo1", q_bo[1], eq);
        check_q("ch0_release_br1", q_br[1], eq);
        chk("ch1_level_kept", {Bo, Br, Bl}, {2'b00, 2'b00, 2'b10});
        Bis = 2'b00; capture(8);
        eq = {6};
        check_q("ch1_release_br1", q_br[1], eq);
        eq.delete();
        check_q("ch1_release_bo1", q_bo[1], eq);

        // Reset during a hold: level drops at once, no release pulse, fresh press after
        Bis = 2'b01; capture(8);
        eq = {6};
        check_q("pre_reset_bo", q_bo[0], eq);
        Rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_reset", {Bo, Br, Bl}, '0);
        capture(3);
        eq.delete();
        check_q("in_reset_br", q_br[0], eq);
        check_q("in_reset_bo", q_bo[0], eq);
        Rst_n = 1'b1;
        capture(10);
        eq = {6};
        check_q("post_reset_bo", q_bo[0], eq);
        eq.delete();
        check_q("post_reset_br", q_br[0], eq);

        // Random segments of glitches and long holds with occasional resets
        for (int c = 0; c < N; c++) rem[c] = 1;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    Bis[c] = ~Bis[c];
                    rem[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                        : int'($urandom_range(4, 40));
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                Rst_n = 1'b0;
                model_clear();
            end else begin
                Rst_n = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_pulse_bank.md
BUTTON_PULSE_BANK -- requirements
Module: button_pulse_bank

Interface
Parameters:
REQ-001 SHALL have N_CH, default 4: number of independent button channels, 1..32.
REQ-002 SHALL have SYNC_STAGES, default 2: synchroniser flops per channel, 2..4.
REQ-003 SHALL have DEBOUNCE_CYCLES, default 1000000: the number of cycles a synchronised level must stay stable to be accepted (20 ms at 50 MHz), 2..2^24.
REQ-004 SHALL have REPEAT_EN, default 0: 1 enables auto-repeat press pulses while a button is held.
REQ-005 SHALL have REPEAT_DELAY, default 25000000: cycles spent held before the first repeat pulse, greater than DEBOUNCE_CYCLES.
REQ-006 SHALL have REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses, 2 or more.

Ports:
REQ-007 SHALL have Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-008 SHALL have Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have Bis, input, N_CH bits: raw, unregistered button inputs, active high.
REQ-010 SHALL have Bo, output, N_CH bits: one-cycle press pulse per channel (also used for repeats).
REQ-011 SHALL have Br, output, N_CH bits: one-cycle release pulse per channel.
REQ-012 SHALL have Bl, output, N_CH bits: debounced level per channel.

Function
REQ-013 SHALL make channels fully independent, with no shared counters or arbitration; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-014 SHALL pass each Bis bit through SYNC_STAGES flops to give the synchronised level s; no other logic SHALL sample Bis.
REQ-015 SHALL give each channel an FSM with states IDLE, PRESS_DB, HELD, REPEAT and REL_DB, plus one counter of width clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) bits.
REQ-016 SHALL move IDLE to PRESS_DB when s=1, clearing the counter.
REQ-017 SHALL, in PRESS_DB, return to IDLE when s=0 with no output; when s=1 it SHALL increment the counter, and on reaching DEBOUNCE_CYCLES-1 it SHALL go to HELD, clear the counter and assert Bo for exactly one cycle.
REQ-018 SHALL, in HELD, go to REL_DB when s=0 (counter cleared); otherwise it SHALL increment the counter, and if REPEAT_EN=1 and the counter reaches REPEAT_DELAY-1 it SHALL go to REPEAT, clear the counter and pulse Bo.
REQ-019 SHALL, in REPEAT, go to REL_DB when s=0; otherwise it SHALL pulse Bo each time the counter reaches REPEAT_PERIOD-1, then clear and continue.
REQ-020 SHALL, in REL_DB, return to HELD when s=1 (counter cleared, no pulse, repeat delay restarts); when s=0 stays for DEBOUNCE_CYCLES cycles it SHALL go to IDLE and pulse Br for one cycle.
REQ-021 SHALL hold Bl=1 in HELD, REPEAT and REL_DB, and Bl=0 in IDLE and PRESS_DB; Bl SHALL be registered and change in the same cycle Bo or Br pulses.
REQ-022 SHALL meet this press latency: if Bis rises before edge 1 and stays high, Bo is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES; release latency to Br SHALL be the same.
REQ-023 SHALL register Bo, Br and Bl directly from flops, with no combinational path from Bis.
REQ-024 SHALL, with REPEAT_EN=0, never enter REPEAT; the HELD counter SHALL saturate rather than wrap.
REQ-025 SHALL treat any glitch shorter than DEBOUNCE_CYCLES (after synchronisation) as producing no pulse and no change of Bl.
REQ-026 SHALL decode unreachable state encodings to IDLE on the next edge with all outputs 0.

Reset
REQ-027 SHALL, while Rst_n=0, clear all synchroniser flops, counters and outputs asynchronously and put every FSM in IDLE.
REQ-028 SHALL emit no Bo or Br pulse due to reset alone on deassertion; a button held through reset SHALL be debounced as a fresh press.
REQ-029 SHALL drop Bl to 0 immediately, with no Br, when reset asserts mid-operation.

Structure
REQ-030 SHALL place the state enum (btn_state_t) and a counter-width helper function in the package button_pkg.
REQ-031 SHALL use one sub-module, button_chan: a single channel holding the synchroniser, FSM and counter, instantiated N_CH times through a generate loop.

Verification
(Bench parameters: N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=5.)
REQ-032 SHALL cover a clean press: Bis[0] rises before edge 1 -> Bo[0] is high only in the cycle after edge 6 and Bl[0] rises at the same time.
REQ-033 SHALL cover a bounce: Bis[0] alternates 1,0,1 for 2-cycle periods, then stays high -> exactly one Bo[0] pulse, 6 cycles after the final rise.
REQ-034 SHALL cover a hold for 30 cycles after Bo -> repeat Bo pulses 10 cycles after the first, then every 5 cycles; Br pulses 6 cycles after the release.
REQ-035 SHALL cover simultaneous channels: Bis=2'b11 at the same edge -> Bo=2'b11 in the same cycle, and Bo[1] is unaffected when Bis[0] is released.
REQ-036 SHALL cover reset mid-hold: Rst_n low while Bl[0]=1 -> Bl=0 and no Br; with Bis still high after reset, Bo is pulsed again 6 cycles after Rst_n deasserts.
